// File: rtl/bcd_pkg.sv
// Shared types and constants for the decimal (BCD) arithmetic datapath.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX  = 4'd9;
  localparam logic [4:0] BCD_BASE = 5'd10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_e;

  // A nibble above 9 is not a legal BCD digit.
  function automatic logic digit_invalid(input bcd_digit_t d);
    return (d > BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_sub.sv
// Single-digit BCD subtractor: d = a - b - bin, borrowing 10 when negative.
// Purely combinational; shared across all digit cycles of the serial top.
module bcd_digit_sub
  import bcd_pkg::*;
(
  input  bcd_digit_t a,
  input  bcd_digit_t b,
  input  logic       bin,
  output bcd_digit_t d,
  output logic       bout
);

  // 5-bit signed difference covers -16..+15, enough even for invalid nibbles.
  logic [4:0] t;

  // Form the raw difference and fold negative values back into 0..9.
  always_comb begin
    t = {1'b0, a} - {1'b0, b} - {4'b0000, bin};
    if (t[4]) begin
      d    = bcd_digit_t'(t + BCD_BASE);
      bout = 1'b1;
    end else begin
      d    = t[3:0];
      bout = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_sub_serial.sv
// Digit-serial N-digit BCD subtractor, LSD first, one digit per clock.
// Handshake: start is sampled only in IDLE; busy is high in RUN and DONE;
// done is a one-cycle pulse in DONE, and diff/bout/err are valid from that
// cycle until the next DONE. start while busy is dropped, never queued.
// Optional invalid-digit checking is compiled in with BCD_SUB_CHECK_EN.
module bcd_sub_serial
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                bin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] diff,
  output logic                bout,
  output logic                err,
  output logic [1:0]          dbg_state
);

  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  sub_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W-1:0]     a_sh_q, a_sh_d;
  logic [W-1:0]     b_sh_q, b_sh_d;
  logic [W-1:0]     res_q, res_d;
  logic             brw_q, brw_d;
  logic [W-1:0]     diff_q, diff_d;
  logic             bout_q, bout_d;
`ifdef BCD_SUB_CHECK_EN
  logic             err_run_q, err_run_d;
  logic             err_q, err_d;
`endif

  bcd_digit_t dig_d;
  logic       dig_bout;

  // Operands shift right so the current digit always sits in the low nibble.
  bcd_digit_sub u_digit (
    .a    (a_sh_q[3:0]),
    .b    (b_sh_q[3:0]),
    .bin  (brw_q),
    .d    (dig_d),
    .bout (dig_bout)
  );

  // Next-state and datapath: latch on start, one digit per RUN cycle, publish on exit.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    brw_d   = brw_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
`ifdef BCD_SUB_CHECK_EN
    err_run_d = err_run_q;
    err_d     = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          brw_d   = bin;
          idx_d   = '0;
          res_d   = '0;
          state_d = RUN;
`ifdef BCD_SUB_CHECK_EN
          err_run_d = 1'b0;
`endif
        end
      end
      RUN: begin
        a_sh_d = a_sh_q >> 4;
        b_sh_d = b_sh_q >> 4;
        // New digit enters at the top; after DIGITS cycles digit 0 is in [3:0].
        res_d  = (res_q >> 4) | (W'(dig_d) << (W - 4));
        brw_d  = dig_bout;
`ifdef BCD_SUB_CHECK_EN
        err_run_d = err_run_q | digit_invalid(a_sh_q[3:0]) |
                    digit_invalid(b_sh_q[3:0]);
`endif
        if (idx_q == LAST_IDX) begin
          // Outputs load on the edge into DONE so they are valid with done.
          diff_d  = res_d;
          bout_d  = dig_bout;
          state_d = DONE;
`ifdef BCD_SUB_CHECK_EN
          err_d = err_run_d;
`endif
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      brw_q   <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
`ifdef BCD_SUB_CHECK_EN
      err_run_q <= 1'b0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      brw_q   <= brw_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
`ifdef BCD_SUB_CHECK_EN
      err_run_q <= err_run_d;
      err_q     <= err_d;
`endif
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign dbg_state = state_q;
`ifdef BCD_SUB_CHECK_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_sub_serial.sv
// Bench for bcd_sub_serial: DIGITS=4 instance for directed/random scenarios,
// DIGITS=1 instance for the exhaustive single-digit sweep.
module tb_bcd_sub_serial;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DIGITS=4 instance ----------------
  logic        start = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        bin = 1'b0;
  logic        busy, done, bout, err;
  logic [15:0] diff;
  logic [1:0]  dbg_state;

  bcd_sub_serial #(.DIGITS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout), .err(err),
    .dbg_state(dbg_state)
  );

  // ---------------- DIGITS=1 instance ----------------
  logic       start1 = 1'b0;
  logic [3:0] a1 = '0, b1 = '0;
  logic       bin1 = 1'b0;
  logic       busy1, done1, bout1, err1;
  logic [3:0] diff1;
  logic [1:0] dbg_state1;

  bcd_sub_serial #(.DIGITS(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .bin(bin1),
    .busy(busy1), .done(done1), .diff(diff1), .bout(bout1), .err(err1),
    .dbg_state(dbg_state1)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [16:0] exp_q[$];            // {bout, diff} per issued operation
  logic [15:0] last_diff_exp = '0;  // what diff must hold between DONEs
  logic        last_bout_exp = 1'b0;

  // Reference: BCD -> integer, subtract, wrap negative by 10^n, back to BCD.
  function automatic logic [15:0] ref_sub(input logic [15:0] x, input logic [15:0] y,
                                          input logic bi, input int n, output logic bo);
    int av, bv, r, p;
    logic [15:0] res;
    av = 0; bv = 0; p = 1;
    for (int i = 0; i < n; i++) begin
      av = av + int'(x[4*i +: 4]) * p;
      bv = bv + int'(y[4*i +: 4]) * p;
      p  = p * 10;
    end
    r  = av - bv - int'(bi);
    bo = (r < 0);
    if (r < 0) r = r + p;
    res = '0;
    for (int i = 0; i < n; i++) begin
      res[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
    return res;
  endfunction

  function automatic logic [15:0] rand_bcd();
    logic [15:0] v;
    for (int i = 0; i < 4; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  // ---------------- driver: one DIGITS=4 operation ----------------
  // Starts in the current (IDLE) cycle, waits for done, checks result and
  // timing, then steps one cycle so the next call is back-to-back.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tbin,
                        input logic chk_val, input logic exp_err, input string nm);
    logic [15:0] ed;
    logic        eb, ee;
    logic [16:0] ex;
    logic        held;
    int          cyc;
    ed = ref_sub(ta, tb_v, tbin, 4, eb);
    exp_q.push_back({eb, ed});
    ee = exp_err;
`ifndef BCD_SUB_CHECK_EN
    ee = 1'b0;
`endif
    a = ta; b = tb_v; bin = tbin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
    cyc  = 1;
    held = 1'b1;
    while (done !== 1'b1 && cyc < 20) begin
      if (busy !== 1'b1 || diff !== last_diff_exp || bout !== last_bout_exp) held = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    ex = exp_q.pop_front();
    total++;
    if (!held) begin
      bad++;
      $display("FAIL %s hold: busy/diff/bout moved during RUN (diff=%h required %h)",
               nm, diff, last_diff_exp);
    end
    total++;
    if (cyc !== 5) begin
      bad++;
      $display("FAIL %s latency: done in cycle %0d required 5", nm, cyc);
    end
    if (chk_val) begin
      total++;
      if (diff !== ex[15:0]) begin
        bad++;
        $display("FAIL %s diff: got %h required %h", nm, diff, ex[15:0]);
      end
      total++;
      if (bout !== ex[16]) begin
        bad++;
        $display("FAIL %s bout: got %b required %b", nm, bout, ex[16]);
      end
      last_diff_exp = ex[15:0];
      last_bout_exp = ex[16];
    end else begin
      last_diff_exp = diff;
      last_bout_exp = bout;
    end
    total++;
    if (err !== ee) begin
      bad++;
      $display("FAIL %s err: got %b required %b", nm, err, ee);
    end
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s pulse: done=%b busy=%b one cycle after done, required 0/0",
               nm, done, busy);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || diff !== 16'h0 || bout !== 1'b0 ||
        err !== 1'b0 || dbg_state !== 2'd0) begin
      bad++;
      $display("FAIL reset4: busy=%b done=%b diff=%h bout=%b err=%b st=%0d required 0s",
               busy, done, diff, bout, err, dbg_state);
    end
    total++;
    if (busy1 !== 1'b0 || done1 !== 1'b0 || diff1 !== 4'h0 || bout1 !== 1'b0) begin
      bad++;
      $display("FAIL reset1: busy=%b done=%b diff=%h bout=%b required 0s",
               busy1, done1, diff1, bout1);
    end
    rst = 1'b0;
    last_diff_exp = '0;
    last_bout_exp = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    run_op(16'h1234, 16'h0567, 1'b0, 1'b1, 1'b0, "d_1234");
    run_op(16'h0000, 16'h0001, 1'b0, 1'b1, 1'b0, "d_under");
    run_op(16'h9999, 16'h9999, 1'b1, 1'b1, 1'b0, "d_9999b");
    run_op(16'h5000, 16'h4999, 1'b1, 1'b1, 1'b0, "d_5000b");
  endtask

  task automatic test_hold_start();
    int n_done, c1, c2;
    logic [15:0] d1, d2;
    n_done = 0; c1 = -1; c2 = -1; d1 = '0; d2 = '0;
    a = 16'h0010; b = 16'h0001; bin = 1'b0; start = 1'b1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 10) start = 1'b0;
      if (done === 1'b1) begin
        n_done++;
        if (n_done == 1) begin c1 = cyc; d1 = diff; end
        if (n_done == 2) begin c2 = cyc; d2 = diff; end
      end
    end
    total++;
    if (n_done !== 2 || c1 !== 5 || c2 !== 11) begin
      bad++;
      $display("FAIL hold_start: %0d dones at %0d,%0d required 2 at 5,11", n_done, c1, c2);
    end
    total++;
    if (d1 !== 16'h0009 || d2 !== 16'h0009) begin
      bad++;
      $display("FAIL hold_start diff: got %h,%h required 0009,0009", d1, d2);
    end
    last_diff_exp = 16'h0009;
    last_bout_exp = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n_done;
    a = 16'h4321; b = 16'h1111; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;          // cycle 1
    start = 1'b0;
    @(posedge clk); #1;          // cycle 2
    rst = 1'b1;
    start = 1'b1;                // rst must win over start
    @(posedge clk); #1;          // cycle 3
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || diff !== 16'h0 || bout !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid: busy=%b done=%b diff=%h bout=%b required 0/0/0000/0",
               busy, done, diff, bout);
    end
    rst = 1'b0;
    start = 1'b0;
    last_diff_exp = '0;
    last_bout_exp = 1'b0;
    n_done = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) n_done++;
    end
    total++;
    if (n_done !== 0) begin
      bad++;
      $display("FAIL reset_mid ghost: %0d done pulses after reset required 0", n_done);
    end
    run_op(16'h0100, 16'h0001, 1'b0, 1'b1, 1'b0, "post_reset");
  endtask

  task automatic test_err();
    run_op(16'h00A0, 16'h0000, 1'b0, 1'b0, 1'b1, "err_set");
    run_op(16'h0042, 16'h0017, 1'b0, 1'b1, 1'b0, "err_clr");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++)
      run_op(rand_bcd(), rand_bcd(), 1'($urandom), 1'b1, 1'b0, "rand");
  endtask

  task automatic test_digits1();
    logic [15:0] ed;
    logic        eb;
    int          cyc;
    for (int ia = 0; ia < 10; ia++)
      for (int ib = 0; ib < 10; ib++)
        for (int ic = 0; ic < 2; ic++) begin
          ed = ref_sub(16'(ia), 16'(ib), 1'(ic), 1, eb);
          a1 = 4'(ia); b1 = 4'(ib); bin1 = 1'(ic); start1 = 1'b1;
          @(posedge clk); #1;
          start1 = 1'b0;
          cyc = 1;
          while (done1 !== 1'b1 && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
          end
          total++;
          if (cyc !== 2 || diff1 !== ed[3:0] || bout1 !== eb) begin
            bad++;
            $display("FAIL d1 %0d-%0d-%0d: cyc=%0d diff=%h bout=%b required cyc=2 diff=%h bout=%b",
                     ia, ib, ic, cyc, diff1, bout1, ed[3:0], eb);
          end
          @(posedge clk); #1;
        end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_directed();
    test_hold_start();
    test_reset_mid();
    test_err();
    test_back_to_back();
    test_digits1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
